// File: rtl/jtag_ir_ctrl_if.sv
// JTAG instruction-register controller bus: TAP-side enables and serial data,
// plus the current instruction, its decode and the short-shift flag.
interface jtag_ir_ctrl_if #(
  parameter int unsigned IR_SIZE = 4
);
  logic                scan_in;
  logic                scan_out;
  logic                CaptureIR;
  logic                ShiftIR;
  logic                UpdateIR;
  logic                TestLogicReset;
  logic [IR_SIZE-3:0]  status_in;
  logic [IR_SIZE-1:0]  data_out;
  logic                dec_extest;
  logic                dec_idcode;
  logic                dec_sample;
  logic                dec_bypass;
  logic                length_error;

  modport master (
    output scan_in, CaptureIR, ShiftIR, UpdateIR, TestLogicReset, status_in,
    input  scan_out, data_out, dec_extest, dec_idcode, dec_sample, dec_bypass,
           length_error
  );

  modport slave (
    input  scan_in, CaptureIR, ShiftIR, UpdateIR, TestLogicReset, status_in,
    output scan_out, data_out, dec_extest, dec_idcode, dec_sample, dec_bypass,
           length_error
  );
endinterface

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: capture/shift scan register, length-checked update
// into the active instruction, and one-hot decode with unknown opcodes as BYPASS.
module jtag_ir_ctrl #(
  parameter int unsigned        IR_SIZE    = 4,
  parameter logic [IR_SIZE-1:0] OPC_EXTEST = '0,
  parameter logic [IR_SIZE-1:0] OPC_IDCODE = IR_SIZE'(1),
  parameter logic [IR_SIZE-1:0] OPC_SAMPLE = IR_SIZE'(2),
  parameter logic [IR_SIZE-1:0] OPC_BYPASS = '1,
  parameter logic [IR_SIZE-1:0] RESET_OPC  = OPC_IDCODE
) (
  input logic             Clock,
  input logic             reset,
  jtag_ir_ctrl_if.slave   bus
);
  localparam int unsigned    CW   = $clog2(IR_SIZE + 1);
  localparam logic [CW-1:0]  FULL = CW'(IR_SIZE);

  logic [IR_SIZE-1:0] scan;
  logic [IR_SIZE-1:0] ir;
  logic [CW-1:0]      cnt;
  logic               len_err;

  // Every branch reads pre-edge values, so scan-side and update-side actions
  // on the same edge see the register contents from before that edge.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      scan    <= {{(IR_SIZE-2){1'b0}}, 2'b01};
      ir      <= RESET_OPC;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      if (bus.CaptureIR)
        scan <= {bus.status_in, 2'b01};
      else if (bus.ShiftIR)
        scan <= {bus.scan_in, scan[IR_SIZE-1:1]};

      if (bus.TestLogicReset || bus.CaptureIR)
        cnt <= '0;
      else if (bus.ShiftIR && cnt != FULL)
        cnt <= cnt + CW'(1);

      if (bus.TestLogicReset) begin
        ir      <= RESET_OPC;
        len_err <= 1'b0;
      end else if (bus.UpdateIR) begin
        if (cnt >= FULL)
          ir <= scan;
        else
          len_err <= 1'b1;
      end else if (bus.CaptureIR) begin
        len_err <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.dec_extest = 1'b0;
    bus.dec_idcode = 1'b0;
    bus.dec_sample = 1'b0;
    bus.dec_bypass = 1'b0;
    if (ir == OPC_EXTEST)
      bus.dec_extest = 1'b1;
    else if (ir == OPC_IDCODE)
      bus.dec_idcode = 1'b1;
    else if (ir == OPC_SAMPLE)
      bus.dec_sample = 1'b1;
    else
      bus.dec_bypass = 1'b1;
  end

  assign bus.scan_out     = scan[0];
  assign bus.data_out     = ir;
  assign bus.length_error = len_err;
endmodule
